// File: rtl/jpeg2k_axis_pkg.sv
// Shared types and helpers for the AXI-stream merge logic feeding the block coder.
package jpeg2k_axis_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned MaxInputs = 32;
  localparam int unsigned PtrWidth  = 5;

  // First set bit of valid strictly after ptr, wrapping modulo n; returns ptr if none set.
  function automatic logic [PtrWidth-1:0] rr_pick(
    input logic [MaxInputs-1:0] valid,
    input logic [PtrWidth-1:0]  ptr,
    input int unsigned          n
  );
    logic        found;
    int unsigned idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MaxInputs; k++) begin
      if (k <= n) begin
        idx = int'(unsigned'(ptr)) + k;
        if (idx >= n) idx = idx - n;
        if (!found && valid[idx[PtrWidth-1:0]]) begin
          rr_pick = idx[PtrWidth-1:0];
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/axis_reg_stage.sv
// Single-entry AXI-stream register; 1-cycle latency, full throughput.
// Backpressure: in_ready = !out_valid | out_ready, forced low while in reset.
module axis_reg_stage #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  input  logic             out_ready
);

  assign in_ready = rst_ni & (!out_valid | out_ready);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of NumInputs AXI streams into one registered output, optional packet lock.
// Latency 1 cycle; sources only see ready when the output register can take a beat.
module axis_rr_arbiter
  import jpeg2k_axis_pkg::*;
#(
  parameter  int NumInputs  = 4,
  parameter  int DataWidth  = 16,
  parameter  int LockOnLast = 1,
  localparam int IdWidth    = $clog2(NumInputs)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumInputs*DataWidth-1:0] s_data_i,
  input  logic [NumInputs-1:0]           s_valid_i,
  input  logic [NumInputs-1:0]           s_last_i,
  output logic [NumInputs-1:0]           s_ready_o,
  output logic [DataWidth-1:0]           m_data_o,
  output logic                           m_last_o,
  output logic [IdWidth-1:0]             m_id_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i
);

  localparam int RegWidth = 1 + IdWidth + DataWidth;

  arb_state_e           state_q, state_d;
  logic [IdWidth-1:0]   grant_q, grant_d;
  logic [IdWidth-1:0]   ptr_q, ptr_d;
  logic [IdWidth-1:0]   sel;
  logic [DataWidth-1:0] sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 reg_ready;
  logic                 accept;
  logic [RegWidth-1:0]  reg_out;

  always_comb begin
    sel = (state_q == LOCKED) ? grant_q
        : IdWidth'(rr_pick(MaxInputs'(s_valid_i), PtrWidth'(ptr_q), NumInputs));
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    s_ready_o = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (sel == IdWidth'(i)) begin
        sel_data     = s_data_i[i*DataWidth +: DataWidth];
        sel_valid    = s_valid_i[i];
        sel_last     = s_last_i[i];
        // A locked grant keeps ready up through gaps in the packet.
        s_ready_o[i] = reg_ready & ((state_q == LOCKED) | s_valid_i[i]);
      end
    end
  end

  assign accept = sel_valid & reg_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if ((LockOnLast != 0) && !sel_last) begin
            state_d = LOCKED;
            grant_d = sel;
          end else begin
            ptr_d = sel;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IdWidth'(NumInputs - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  axis_reg_stage #(
    .Width(RegWidth)
  ) u_out_reg (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_valid (sel_valid),
    .in_data  ({sel_last, sel, sel_data}),
    .in_ready (reg_ready),
    .out_valid(m_valid_o),
    .out_data (reg_out),
    .out_ready(m_ready_i)
  );

  assign m_last_o = reg_out[RegWidth-1];
  assign m_id_o   = reg_out[DataWidth +: IdWidth];
  assign m_data_o = reg_out[DataWidth-1:0];

endmodule
